aes_out_unmask_serializer: RTL
==============================

AES_OUT_UNMASK_SERIALIZER -- requirements
Module: aes_out_unmask_serializer

Interface
REQ-001 SHALL have parameter d, default 2, meaning number of Boolean shares per bit (d >= 1).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, shared ciphertext present.
REQ-005 SHALL have port in_ready, output, 1, block accepts a shared ciphertext.
REQ-006 SHALL have port in_shares_ciphertext, input, 128*d, the shares; share i occupies bits [128*i +: 128].
REQ-007 SHALL have port out_valid, output, 1, out_data holds a valid word.
REQ-008 SHALL have port out_ready, input, 1, downstream accepts a word.
REQ-009 SHALL have port out_data, output, 32, one unmasked ciphertext word.
REQ-010 SHALL have port out_last, output, 1, high with the fourth word of a block.

Function
REQ-011 SHALL have FSM states IDLE and SEND, plus a 2-bit word counter wcnt.
REQ-012 IDLE: in_ready=1, out_valid=0; SEND: in_ready=0, out_valid=1.
REQ-013 Input transfer (in_valid & in_ready, rising edge): capture all 128*d share bits unchanged, set wcnt=0, go to SEND.
REQ-014 Latency: out_valid SHALL rise in the cycle after the input transfer.
REQ-015 In SEND, out_data SHALL equal the XOR over all d shares of bits [32*wcnt +: 32]; recombination happens only at the output word mux, and the capture register holds shares only.
REQ-016 Output transfer (out_valid & out_ready): if wcnt<3, increment wcnt; if wcnt==3, go to IDLE.
REQ-017 out_last SHALL be 1 only when in SEND with wcnt==3.
REQ-018 When out_valid=1 and out_ready=0, out_data, out_last and wcnt SHALL hold stable until the transfer.
REQ-019 No overlap: a new input SHALL be accepted only from IDLE, so the minimum period is 5 cycles per block with out_ready held high.
REQ-020 in_valid asserted in SEND SHALL be ignored and not lost; the upstream holds it until in_ready.
REQ-021 in_shares_ciphertext changing while in SEND SHALL have no effect on out_data.

Reset
REQ-022 Reset low SHALL immediately force IDLE, wcnt=0, out_valid=0, in_ready=1 (once released), out_last=0, and clear the share register to 0.
REQ-023 Reset asserted mid-block SHALL discard the partially sent block; after release, no stale word is emitted.
REQ-024 in_ready SHALL be 0 while rst is low.

Configuration
REQ-025 Macro AES_OUT_BYTE_SWAP_EN defined: each out_data word SHALL be byte-reversed, so recombined byte 0 (bits [7:0]) of the word appears at out_data[31:24].
REQ-026 Macro AES_OUT_BYTE_SWAP_EN undefined: out_data SHALL carry the word bits in natural order; no other behaviour differs.

Structure
REQ-027 Shared package SHALL hold the constants BLOCK_BITS=128, WORD_BITS=32, WORDS_PER_BLOCK=4 and the FSM state encoding.
REQ-028 One sub-module shares_xor_fold (parameters d and count) SHALL perform the XOR recombination of a count-bit slice; it is instantiated once on the selected 32-bit slice.

Verification
REQ-029 Scenario 1: d=2, share0=0x00112233_44556677_8899aabb_ccddeeff XOR R, share1=R (R random), out_ready=1 -> words 0xccddeeff, 0x8899aabb, 0x44556677, 0x00112233 on cycles +1..+4, with out_last only on the 4th word; in_ready returns at +5.
REQ-030 Scenario 2: same input with AES_OUT_BYTE_SWAP_EN defined -> first word 0xffeeddcc, last word 0x33221100.
REQ-031 Scenario 3: out_ready = pseudo-random bit per cycle over 1000 blocks from FIPS-197 vectors (ciphertext 0x69c4e0d8...c55a) -> every recombined block matches; no word is dropped or duplicated; out_data stays stable while stalled.
REQ-032 Scenario 4: in_valid held high continuously, with in_shares changing every cycle during SEND -> only the value present at each accept edge is emitted; input transfers are exactly 5 cycles apart.
REQ-033 Scenario 5: rst pulled low after the 2nd word is accepted -> out_valid=0 immediately; after release, in_ready=1 and the next block starts with its own word 0.
REQ-034 Scenario 6: d=1 and d=4 builds with Scenario 1 data -> identical output words.

Source files
------------

// File: rtl/aes_out_unmask_serializer_pkg.sv
// Shared constants, FSM encoding and helpers for the AES output unmask serializer.
package aes_out_unmask_serializer_pkg;

   localparam int BLOCK_BITS      = 128;
   localparam int WORD_BITS       = 32;
   localparam int WORDS_PER_BLOCK = 4;
   localparam int WCNT_W          = 2;
   localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS_PER_BLOCK - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   function automatic logic [WORD_BITS-1:0] byte_swap32(input logic [WORD_BITS-1:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/aes_out_unmask_serializer_shares_xor_fold.sv
// XOR recombination of d Boolean shares of a count-bit slice; share i sits at [count*i +: count].
module shares_xor_fold #(
   parameter int d     = 2,
   parameter int count = 32
) (
   input  logic [count*d-1:0] shares_i,
   output logic [count-1:0]   data_o
);

   always_comb begin
      data_o = '0;
      for (int i = 0; i < d; i++) begin
         data_o = data_o ^ shares_i[count*i +: count];
      end
   end

endmodule

// File: rtl/aes_out_unmask_serializer.sv
// Captures a d-share masked ciphertext block and streams it as four unmasked 32-bit words.
// Optional AES_OUT_BYTE_SWAP_EN byte-reverses every output word.
module aes_out_unmask_serializer
   import aes_out_unmask_serializer_pkg::*;
#(
   parameter int d = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [BLOCK_BITS*d-1:0] in_shares_ciphertext,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WORD_BITS-1:0]    out_data,
   output logic                    out_last
);

   // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
   // the sender holds valid and its payload until that edge.

   state_e                  state_q, state_d;
   logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
   logic [BLOCK_BITS*d-1:0] shares_q, shares_d;
   logic [WORD_BITS*d-1:0]  word_shares;
   logic [WORD_BITS-1:0]    word_plain;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         wcnt_q   <= '0;
         shares_q <= '0;
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         shares_q <= shares_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      shares_d = shares_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               shares_d = in_shares_ciphertext;
               wcnt_d   = '0;
               state_d  = ST_SEND;
            end
         end
         ST_SEND: begin
            if (out_ready) begin
               if (wcnt_q == LAST_WORD) begin
                  wcnt_d  = '0;
                  state_d = ST_IDLE;
               end else begin
                  wcnt_d = wcnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Shares stay separate in the register; only the selected word is recombined.
   always_comb begin
      word_shares = '0;
      for (int i = 0; i < d; i++) begin
         word_shares[WORD_BITS*i +: WORD_BITS] =
            shares_q[BLOCK_BITS*i + WORD_BITS*int'(wcnt_q) +: WORD_BITS];
      end
   end

   shares_xor_fold #(
      .d    (d),
      .count(WORD_BITS)
   ) u_fold (
      .shares_i(word_shares),
      .data_o  (word_plain)
   );

   always_comb begin
      in_ready  = (state_q == ST_IDLE) && rst;
      out_valid = (state_q == ST_SEND);
      out_last  = (state_q == ST_SEND) && (wcnt_q == LAST_WORD);
`ifdef AES_OUT_BYTE_SWAP_EN
      out_data  = byte_swap32(word_plain);
`else
      out_data  = word_plain;
`endif
   end

endmodule
